// File: rtl/gpio_sequencer.sv
// Timed GPIO pattern player: host loads {value, hold} entries, FSM writes each value
// to GPIO register 0x00 and holds it for a programmed number of ticks.
module gpio_sequencer #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 8,
  parameter int DEPTH        = 8,
  parameter int CLK_FREQ     = 12000000,
  parameter int TICK_HZ      = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDRESS_BITS-1:0] i_address,
  input  logic [BITS-1:0]         i_data_in,
  output logic [BITS-1:0]         o_data_out,
  input  logic                    i_wr,
  output logic [7:0]              o_gpio_address,
  output logic [BITS-1:0]         o_gpio_data,
  output logic                    o_gpio_wr,
  output logic                    o_done
);

  // state | meaning
  // IDLE  | not playing
  // EMIT  | one-cycle GPIO write in flight, counters load
  // HOLD  | value held, hold counter ticking down
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam int TICK_CYCLES = CLK_FREQ / TICK_HZ;
  localparam int PW          = $clog2(TICK_CYCLES);
  localparam int IW          = $clog2(DEPTH);
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_CYCLES - 1);
  localparam logic [4:0]    DEPTH_L      = 5'(DEPTH);

  localparam logic [ADDRESS_BITS-1:0] A_CTRL   = ADDRESS_BITS'(8'h00);
  localparam logic [ADDRESS_BITS-1:0] A_STATUS = ADDRESS_BITS'(8'h01);
  localparam logic [ADDRESS_BITS-1:0] A_LEN    = ADDRESS_BITS'(8'h02);
  localparam logic [ADDRESS_BITS-1:0] A_TBL    = ADDRESS_BITS'(8'h10);

  logic [1:0]    r_state;
  logic [IW-1:0] r_index;
  logic [4:0]    r_length;
  logic          r_loop;
  logic [15:0]   r_table [DEPTH];
  logic [PW-1:0] r_presc;
  logic [7:0]    r_hold_cnt;
  logic [7:0]    r_gpio_data;
  logic          r_gpio_wr;
  logic          r_done;

  logic                    w_ctrl_wr;
  logic                    w_start;
  logic                    w_stop;
  logic [ADDRESS_BITS-1:0] w_tbl_off;
  logic                    w_tbl_hit;
  logic [IW-1:0]           w_tbl_idx;
  logic [4:0]              w_len_wdata;
  logic                    w_last;
  logic [IW-1:0]           w_adv_idx;
  logic [7:0]              w_cur_hold;
  logic [7:0]              w_load_hold;
  logic                    w_tick;
  logic                    w_busy;
  logic                    w_unused_data;

  assign w_ctrl_wr   = i_wr && (i_address == A_CTRL);
  assign w_stop      = w_ctrl_wr && i_data_in[1];
  assign w_start     = w_ctrl_wr && i_data_in[0] && !i_data_in[1] && (r_length != 5'd0);
  assign w_tbl_off   = i_address - A_TBL;
  assign w_tbl_hit   = (i_address >= A_TBL) && (w_tbl_off < ADDRESS_BITS'(DEPTH));
  assign w_tbl_idx   = w_tbl_off[IW-1:0];
  assign w_len_wdata = (i_data_in[4:0] > DEPTH_L) ? DEPTH_L : i_data_in[4:0];
  assign w_unused_data = ^i_data_in;

  // A LENGTH shrunk below the current position makes the current entry the last one.
  assign w_last      = ((5'(r_index) + 5'd1) >= r_length);
  assign w_adv_idx   = w_last ? '0 : r_index + IW'(1);
  assign w_cur_hold  = r_table[r_index][15:8];
  assign w_load_hold = (w_cur_hold == 8'd0) ? 8'd1 : w_cur_hold;
  assign w_tick      = (r_presc == '0);
  assign w_busy      = (r_state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_length <= '0;
      r_loop   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (i_wr) begin
      if (i_address == A_CTRL) r_loop <= i_data_in[2];
      if (i_address == A_LEN) r_length <= w_len_wdata;
      if (w_tbl_hit) r_table[w_tbl_idx] <= i_data_in[15:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_presc     <= '0;
      r_hold_cnt  <= '0;
      r_gpio_data <= '0;
      r_gpio_wr   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_gpio_wr <= 1'b0;
      r_done    <= 1'b0;
      if (w_stop) begin
        r_state <= S_IDLE;
      end else if (w_start) begin
        r_state     <= S_EMIT;
        r_index     <= '0;
        r_gpio_wr   <= 1'b1;
        r_gpio_data <= r_table[0][7:0];
      end else begin
        case (r_state)
          S_EMIT: begin
            r_presc    <= PRESC_RELOAD;
            r_hold_cnt <= w_load_hold;
            r_state    <= S_HOLD;
          end
          S_HOLD: begin
            if (!w_tick) begin
              r_presc <= r_presc - PW'(1);
            end else begin
              r_presc <= PRESC_RELOAD;
              if (r_hold_cnt > 8'd1) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
              end else if (!w_last || r_loop) begin
                r_index     <= w_adv_idx;
                r_state     <= S_EMIT;
                r_gpio_wr   <= 1'b1;
                r_gpio_data <= r_table[w_adv_idx][7:0];
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_data_out = '0;
    if (i_address == A_CTRL) begin
      o_data_out[2] = r_loop;
    end else if (i_address == A_STATUS) begin
      o_data_out[0]   = w_busy;
      o_data_out[7:4] = 4'(r_index);
    end else if (i_address == A_LEN) begin
      o_data_out[4:0] = r_length;
    end else if (w_tbl_hit) begin
      o_data_out[15:0] = r_table[w_tbl_idx];
    end
  end

  assign o_gpio_address = 8'h00;
  assign o_gpio_data    = {{(BITS-8){1'b0}}, r_gpio_data};
  assign o_gpio_wr      = r_gpio_wr;
  assign o_done         = r_done;

endmodule

// File: tb/tb_gpio_sequencer.sv
// Bench for gpio_sequencer: directed scenarios plus random tables, checked against
// pulse times derived from the table with plain arithmetic.
module tb_gpio_sequencer;
  localparam int TC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        wr;
  logic [7:0]  gaddr;
  logic [15:0] gdata;
  logic        gwr;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_tab [8];
  int          m_len;
  bit          m_loop;

  always #5 clk = ~clk;

  gpio_sequencer #(.BITS(16), .ADDRESS_BITS(8), .DEPTH(8), .CLK_FREQ(100), .TICK_HZ(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_address(addr), .i_data_in(din), .o_data_out(dout),
    .i_wr(wr), .o_gpio_address(gaddr), .o_gpio_data(gdata), .o_gpio_wr(gwr), .o_done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d);
    addr = a; din = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    if (a == 8'h00) m_loop = d[2];
    if (a == 8'h02) m_len = (d[4:0] > 5'd8) ? 8 : int'(d[4:0]);
    if (a >= 8'h10 && a < 8'h18) m_tab[a - 8'h10] = d;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic quiet(input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      tick();
      chk({tag, "_wr"}, gwr, 0);
      chk({tag, "_done"}, done, 0);
    end
  endtask

  function automatic int hold_clks(input logic [15:0] e);
    return ((e[15:8] == 8'd0) ? 1 : int'(e[15:8])) * TC + 1;
  endfunction

  // Call right after the START write; sample 0 is the first emitted cycle.
  task automatic check_run(input int n_loop, input bit lp);
    int pt[$];
    logic [7:0] pv[$];
    int pidx[$];
    int t, i, done_t, n, p, cur;
    logic [15:0] s;
    bit exp_wr;
    t = 0; i = 0; done_t = -1; p = 0; cur = 0;
    if (lp) begin
      while (t < n_loop) begin
        pt.push_back(t); pv.push_back(m_tab[i][7:0]); pidx.push_back(i);
        t += hold_clks(m_tab[i]);
        i = (i + 1) % m_len;
      end
      n = n_loop;
    end else begin
      for (i = 0; i < m_len; i++) begin
        pt.push_back(t); pv.push_back(m_tab[i][7:0]); pidx.push_back(i);
        t += hold_clks(m_tab[i]);
      end
      done_t = t;
      n = done_t + 3;
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      exp_wr = (p < pt.size()) && (pt[p] == k);
      chk("gpio_wr", gwr, exp_wr);
      if (exp_wr) begin
        chk("gpio_data", gdata, {8'h00, pv[p]});
        cur = pidx[p];
        p++;
      end
      chk("done", done, (k == done_t));
      rd(8'h01, s);
      chk("status", s, {8'h00, 4'(cur), 3'b000, (lp || k < done_t)});
    end
  endtask

  initial begin
    logic [15:0] s;
    int len, e;
    rst = 1'b1; wr = 1'b0; addr = 8'h00; din = 16'h0000;
    m_len = 0; m_loop = 0;
    for (int i = 0; i < 8; i++) m_tab[i] = 16'h0000;
    #12;
    chk("rst_wr", gwr, 0);
    chk("rst_done", done, 0);
    chk("rst_gdata", gdata, 0);
    chk("rst_gaddr", gaddr, 0);
    rd(8'h01, s); chk("rst_status", s, 0);
    rst = 1'b0;
    tick();

    // LENGTH == 0 start is ignored; LENGTH clamps
    host_write(8'h00, 16'h0001);
    chk("len0_wr", gwr, 0);
    quiet(25, "len0");
    rd(8'h01, s); chk("len0_status", s, 0);
    host_write(8'h02, 16'd31);
    rd(8'h02, s); chk("len_clamp", s, 16'd8);

    // basic two-entry run
    host_write(8'h10, 16'h02A5);
    host_write(8'h11, 16'h013C);
    host_write(8'h02, 16'd2);
    rd(8'h10, s); chk("tbl0_rb", s, m_tab[0]);
    host_write(8'h00, 16'h0001);
    check_run(0, 0);

    // loop, then stop
    host_write(8'h00, 16'h0005);
    rd(8'h00, s); chk("loop_rb", s, 16'h0004);
    check_run(80, 1);
    host_write(8'h00, 16'h0002);
    chk("stop_wr", gwr, 0);
    quiet(25, "stop");
    rd(8'h01, s); chk("stop_busy", s[0], 0);

    // hold 0 behaves as hold 1; START+STOP when idle does nothing
    host_write(8'h10, 16'h0011);
    host_write(8'h11, 16'h0022);
    host_write(8'h12, 16'h0133);
    host_write(8'h02, 16'd3);
    host_write(8'h00, 16'h0001);
    check_run(0, 0);
    host_write(8'h00, 16'h0003);
    chk("ss_wr", gwr, 0);
    quiet(25, "ss");
    rd(8'h01, s); chk("ss_busy", s[0], 0);

    // table rewrite mid-run and restart mid-hold
    host_write(8'h10, 16'h02A5);
    host_write(8'h11, 16'h013C);
    host_write(8'h02, 16'd2);
    host_write(8'h00, 16'h0001);
    chk("rs_wr0", gwr, 1); chk("rs_d0", gdata, 16'h00A5);
    host_write(8'h11, 16'h0177);
    chk("rs_wr1", gwr, 0);
    quiet(19, "rs_a");
    tick();
    chk("rs_wr21", gwr, 1); chk("rs_d21", gdata, 16'h0077);
    quiet(4, "rs_b");
    host_write(8'h00, 16'h0001);
    chk("rs_restart_wr", gwr, 1); chk("rs_restart_d", gdata, 16'h00A5);
    quiet(20, "rs_c");
    tick();
    chk("rs_wr_next", gwr, 1); chk("rs_d_next", gdata, 16'h0077);
    host_write(8'h00, 16'h0002);
    quiet(3, "rs_stop");

    // random tables
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++)
        host_write(8'h10 + 8'(i), {8'($urandom_range(0, 3)), 8'($urandom)});
      host_write(8'h02, 16'(len));
      e = $urandom_range(0, 7);
      rd(8'h10 + 8'(e), s); chk("rnd_tbl_rb", s, m_tab[e]);
      if (r == 5) begin
        host_write(8'h00, 16'h0005);
        check_run(120, 1);
        host_write(8'h00, 16'h0002);
        quiet(5, "rnd_stop");
      end else begin
        host_write(8'h00, 16'h0001);
        check_run(0, 0);
      end
    end

    // async reset while GPIO_WR is high
    host_write(8'h10, 16'h02A5);
    host_write(8'h02, 16'd2);
    host_write(8'h00, 16'h0001);
    chk("ar_pre_wr", gwr, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_wr", gwr, 0);
    chk("ar_done", done, 0);
    chk("ar_gdata", gdata, 0);
    rd(8'h01, s); chk("ar_status", s, 0);
    #2 rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      rd(8'h10 + 8'(i), s); chk("ar_tbl", s, 0);
    end
    rd(8'h02, s); chk("ar_len", s, 0);
    rd(8'h00, s); chk("ar_ctrl", s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
